// File: rtl/bcd_display_formatter.sv
// bcd_display_formatter: signed 18-bit to six-digit blanked BCD display codes via serial double-dabble.
module bcd_display_formatter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [17:0] din,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [23:0] digits
);
  typedef enum logic [1:0] {IDLE, CONV, FMT} state_t;
  state_t state_q;
  logic [4:0] cnt_q;
  logic [23:0] acc_q, adj_d, digits_d;
  logic [17:0] mag_q;
  logic [18:0] mag_d;
  logic sign_q, ovf_d, lead_z;
  assign busy = state_q != IDLE;
  assign mag_d = din[17] ? -{din[17], din} : {din[17], din};
  always_comb begin
    adj_d = acc_q;
    for (int i = 0; i < 6; i++)
      adj_d[4*i +: 4] = acc_q[4*i +: 4] >= 4'd5 ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
  end
  // Blank leading zeros, then drop the minus sign into the blank just left of the first digit.
  always_comb begin
    digits_d = acc_q;
    lead_z = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      lead_z = lead_z & (acc_q[4*i +: 4] == 4'd0);
      digits_d[4*i +: 4] = lead_z ? 4'hC : acc_q[4*i +: 4];
    end
    if (sign_q)
      for (int i = 5; i >= 1; i--)
        if (digits_d[4*i +: 4] == 4'hC && digits_d[4*i-4 +: 4] != 4'hC) digits_d[4*i +: 4] = 4'hA;
    ovf_d = sign_q && acc_q[23:20] != 4'd0;
    if (ovf_d) digits_d = 24'hAAAAAA;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      digits  <= 24'hCCCCCC;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          sign_q  <= din[17];
          mag_q   <= mag_d[17:0];
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= CONV;
        end
        CONV: if (cnt_q == 5'd18) state_q <= FMT;
        else begin
          acc_q <= {adj_d[22:0], mag_q[17]};
          mag_q <= {mag_q[16:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
        end
        default: begin
          digits  <= digits_d;
          ovf     <= ovf_d;
          done    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_display_formatter.sv
// tb_bcd_display_formatter: directed vectors against hand-computed display codes and timing.
module tb_bcd_display_formatter;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [17:0] din = '0;
  logic busy, done, ovf;
  logic [23:0] digits;
  int checks = 0, failures = 0;
  bcd_display_formatter dut (.clk(clk), .rst(rst), .start(start), .din(din),
    .busy(busy), .done(done), .ovf(ovf), .digits(digits));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic kick(input int d);
    din = d[17:0];
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(output int k, output bit busy_ok);
    k = 0;
    busy_ok = busy;
    while (k < 30) begin
      @(posedge clk);
      #1 k++;
      if (done) break;
      busy_ok &= busy;
    end
  endtask
  task automatic convert(input string tag, input int d, input logic [23:0] exp_dig, input bit exp_ovf);
    int k;
    bit bok;
    @(negedge clk);
    kick(d);
    wait_done(k, bok);
    check({tag, "_lat"}, k, 20);
    check({tag, "_busy"}, bok, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_dig"}, digits, exp_dig);
    check({tag, "_ovf"}, ovf, exp_ovf);
    @(posedge clk);
    #1 check({tag, "_done_1cyc"}, done, 0);
  endtask
  initial begin
    int k, nd;
    bit bok;
    #12 rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1 check("idle", {digits, busy, done, ovf}, {24'hCCCCCC, 3'b000});
    end
    convert("p12345", 12345, 24'hC12345, 0);
    convert("n42", -42, 24'hCCCA42, 0);
    convert("zero", 0, 24'hCCCCC0, 0);
    convert("max", 131071, 24'h131071, 0);
    convert("n99999", -99999, 24'hA99999, 0);
    convert("n1", -1, 24'hCCCCA1, 0);
    convert("p100000", 100000, 24'h100000, 0);
    convert("n100000", -100000, 24'hAAAAAA, 1);
    // start pulses and din changes while busy must be ignored
    @(negedge clk);
    kick(777);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (i >= 4 && i < 8) begin start = 1'b1; din = 18'h3FFFD; end
      else start = 1'b0;
      @(posedge clk);
      #1 nd += done;
      if (done) check("ign_dig", digits, 24'hCCC777);
    end
    start = 1'b0;
    check("ign_single_done", nd, 1);
    convert("min", -131072, 24'hAAAAAA, 1);
    // back-to-back: start issued in the done cycle
    @(negedge clk);
    kick(5);
    wait_done(k, bok);
    check("b2b_first", digits, 24'hCCCCC5);
    kick(-8);
    check("b2b_accepted", busy, 1);
    wait_done(k, bok);
    check("b2b_lat", k, 20);
    check("b2b_dig", digits, 24'hCCCCA8);
    // reset mid-conversion, after ovf was set by an overflow result
    convert("n120000", -120000, 24'hAAAAAA, 1);
    @(negedge clk);
    kick(4321);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_async", {digits, busy, done, ovf}, {24'hCCCCCC, 3'b000});
    @(negedge clk) rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1 nd += done;
    end
    check("rst_no_done", nd, 0);
    convert("post_rst", 4321, 24'hCC4321, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_display_formatter.md
BCD_DISPLAY_FORMATTER -- requirements
Module: bcd_display_formatter

Interface
REQ-001 Parameters: none; all widths SHALL be fixed as listed below.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to convert din; sampled only in IDLE.
REQ-005 din  input  18  signed two's-complement value, range -131072..131071.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse when digits holds a new result.
REQ-008 ovf  output  1  high when the last result did not fit the display.
REQ-009 digits  output  24  six 4-bit display codes; [23:20]=d5 (leftmost) .. [3:0]=d0 (rightmost).
REQ-010 Each digit code SHALL be one of: 0-9 = decimal digit, 10 = minus sign, 12 = blank; codes 11 and 13-15 SHALL never be driven.

Function
REQ-011 States SHALL be IDLE, CONV and FMT; reset state IDLE.
REQ-012 IDLE: on a rising edge with start=1, the block SHALL capture sign=din[17] and mag=|din| (19-bit, so 131072 is exact), clear the BCD accumulator, load iteration counter 0 and enter CONV.
REQ-013 CONV: the block SHALL perform one shift-add-3 (double-dabble) iteration per cycle on a 24-bit BCD accumulator, MSB of mag first, for exactly 18 cycles, then enter FMT.
REQ-014 Before each shift, every BCD nibble >= 5 SHALL have 3 added; no nibble SHALL exceed 9 after the final iteration.
REQ-015 FMT: one cycle; the block SHALL register digits, ovf and pulse done, then return to IDLE.
REQ-016 Latency: start sampled at edge N -> digits/ovf updated and done=1 at edge N+20; done SHALL be high for exactly one cycle.
REQ-017 busy SHALL be 1 from edge N through edge N+20 exclusive, i.e. 1 in CONV and FMT, 0 in IDLE; busy SHALL be 0 in the cycle where done=1.
REQ-018 start while busy=1 SHALL be ignored with no queuing; start in the cycle done=1 SHALL be accepted.
REQ-019 digits and ovf SHALL hold their previous values throughout CONV and FMT and change only at the FMT edge (no partial updates).
REQ-020 Leading-zero blanking: every BCD digit left of the most significant nonzero digit SHALL be driven 12; d0 SHALL always show its digit (value 0 -> d0=0, d5..d1=12).
REQ-021 Negative, mag <= 99999: code 10 SHALL be placed immediately left of the most significant nonzero digit; all positions further left SHALL be 12.
REQ-022 Negative, mag >= 100000: all six digits SHALL be 10 and ovf=1.
REQ-023 Positive values (0..131071) SHALL always fit; ovf=0 for every non-overflow result.
REQ-024 din changes after the capture edge SHALL not affect the conversion in progress.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, busy=0, done=0, ovf=0, digits=24'hCCCCCC (all blank), counter and accumulator to 0.
REQ-026 Reset asserted mid-conversion SHALL abort it; no done pulse SHALL follow reset release.
REQ-027 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-028 Assert rst, release; no start -> digits=CCCCCC, busy=0, done=0, ovf=0 for 50 cycles.
REQ-029 din=12345, start pulse at edge N -> busy=1 for 20 cycles, done=1 at edge N+20 only, digits=C12345, ovf=0.
REQ-030 din=-42 -> digits=CCCA42; din=0 -> digits=CCCCC0; din=131071 -> digits=131071, ovf=0.
REQ-031 din=-99999 -> digits=A99999, ovf=0; din=-100000 and din=-131072 -> digits=AAAAAA, ovf=1.
REQ-032 Start pulses during CONV plus a din change after capture -> single done, result of the captured value; start in the done cycle -> second conversion starts immediately.
REQ-033 rst pulse at cycle 10 of a conversion -> immediate reset values, no done pulse, next start converts correctly.
